// File: rtl/board_controller.sv
// Settled-block playfield: locks landed piece cells into the board, then
// clears full rows bottom-up and keeps per-lock and running line counts.
module board_controller #(
    parameter int ROWS    = 20,
    parameter int COLS    = 10,
    parameter int TOTAL_W = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       lock_req,
    input  logic                       clear_board,
    input  logic [9:0]                 x0,
    input  logic [9:0]                 x1,
    input  logic [9:0]                 x2,
    input  logic [9:0]                 x3,
    input  logic [9:0]                 y0,
    input  logic [9:0]                 y1,
    input  logic [9:0]                 y2,
    input  logic [9:0]                 y3,
    output logic [ROWS-1:0][COLS-1:0]  board,
    output logic                       busy,
    output logic                       lock_done,
    output logic [2:0]                 lines_last,
    output logic [TOTAL_W-1:0]         lines_total,
    output logic                       game_over
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [2:0] {IDLE, LOCK, SCAN, SHIFT, DONE} state_t;

    state_t                state, state_next;
    logic [3:0][9:0]       cx, cy;
    logic [RW-1:0]         row;
    logic [2:0]            cnt;
    logic                  row_full;
    logic [RW-1:0]         scan_last;
    logic [TOTAL_W:0]      total_sum;

    assign row_full  = &board[row];
    // Each shift leaves a zero row on top, so the scan can stop one row lower
    // per cleared line; this keeps the sequence at 21 edges + 1 per cleared row.
    assign scan_last = RW'(ROWS - 1) - RW'(cnt);
    assign total_sum = {1'b0, lines_total} + {{(TOTAL_W-2){1'b0}}, cnt};

    assign busy      = (state != IDLE);
    assign lock_done = (state == DONE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!clear_board && lock_req) state_next = LOCK;
            LOCK:    state_next = SCAN;
            SCAN: begin
                if (row_full)               state_next = SHIFT;
                else if (row >= scan_last)  state_next = DONE;
            end
            SHIFT:   state_next = SCAN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            board       <= '0;
            cx          <= '0;
            cy          <= '0;
            row         <= '0;
            cnt         <= '0;
            lines_last  <= '0;
            lines_total <= '0;
            game_over   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_board) begin
                        board       <= '0;
                        lines_last  <= '0;
                        lines_total <= '0;
                        game_over   <= 1'b0;
                    end else if (lock_req) begin
                        cx <= {x3, x2, x1, x0};
                        cy <= {y3, y2, y1, y0};
                    end
                end
                LOCK: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (cy[i] >= 10'(ROWS))
                            game_over <= 1'b1;
                        else if (cx[i] < 10'(COLS))
                            board[cy[i][RW-1:0]][cx[i][CW-1:0]] <= 1'b1;
                    end
                    row <= '0;
                    cnt <= '0;
                end
                SCAN: begin
                    if (!row_full) begin
                        if (row >= scan_last) begin
                            lines_last  <= cnt;
                            lines_total <= total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    for (int unsigned r = 0; r < ROWS - 1; r++) begin
                        if (r >= 32'(row)) board[r] <= board[r+1];
                    end
                    board[ROWS-1] <= '0;
                    cnt <= (cnt == 3'd4) ? cnt : cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: locks, line clears, latency, game over,
// arbitration and asynchronous reset.
module tb_board_controller;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    logic                      Clk = 1'b0;
    logic                      Reset = 1'b1;
    logic                      lock_req = 1'b0;
    logic                      clear_board = 1'b0;
    logic [9:0]                x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic [9:0]                y0 = '0, y1 = '0, y2 = '0, y3 = '0;
    logic [ROWS-1:0][COLS-1:0] board;
    logic                      busy, lock_done, game_over;
    logic [2:0]                lines_last;
    logic [15:0]               lines_total;

    logic [ROWS-1:0][COLS-1:0] exp;
    int                        errors = 0;
    int                        checks = 0;
    int                        lat;

    board_controller #(.ROWS(ROWS), .COLS(COLS), .TOTAL_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .lock_req(lock_req), .clear_board(clear_board),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .board(board), .busy(busy), .lock_done(lock_done),
        .lines_last(lines_last), .lines_total(lines_total), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    // Issues a one-cycle lock and returns edges from acceptance to lock_done (-1 on timeout).
    task automatic do_lock(input int xa, xb, xc, xd, ya, yb, yc, yd, output int l);
        @(negedge Clk);
        x0 = 10'(xa); x1 = 10'(xb); x2 = 10'(xc); x3 = 10'(xd);
        y0 = 10'(ya); y1 = 10'(yb); y2 = 10'(yc); y3 = 10'(yd);
        lock_req = 1'b1;
        @(posedge Clk); #1 lock_req = 1'b0;
        l = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge Clk); #1;
            if (lock_done) begin l = e; break; end
        end
        @(posedge Clk); #1;
    endtask

    task automatic do_clear();
        @(negedge Clk); clear_board = 1'b1;
        @(posedge Clk); #1 clear_board = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk); #1;
        checks++; if (board !== '0) begin errors++; $display("FAIL reset_board got %h expected 0", board); end
        checks++; if ({busy, lock_done, game_over} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {busy, lock_done, game_over}); end
        checks++; if (lines_total !== 16'd0 || lines_last !== 3'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d expected 0/0", lines_total, lines_last); end
        @(negedge Clk); Reset = 1'b0;
    endtask

    task automatic test_single_lock();
        do_lock(0, 1, 2, 3, 0, 0, 0, 0, lat);
        exp = '0; exp[0] = 10'h00F;
        checks++; if (lat !== 21) begin errors++; $display("FAIL single_lock_latency got %0d expected 21", lat); end
        checks++; if (board !== exp) begin errors++; $display("FAIL single_lock_board got %h expected %h", board, exp); end
        checks++; if (lines_last !== 3'd0 || lines_total !== 16'd0) begin errors++; $display("FAIL single_lock_counts got %0d/%0d expected 0/0", lines_last, lines_total); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_lock_busy got %b expected 0", busy); end
    endtask

    task automatic test_single_clear();
        do_clear();
        do_lock(4, 5, 6, 7, 0, 0, 0, 0, lat);
        do_lock(8, 9, 0, 0, 0, 0, 1, 1, lat);
        exp = '0; exp[0] = 10'h3F0; exp[1] = 10'h001;
        checks++; if (board !== exp) begin errors++; $display("FAIL clear1_preload got %h expected %h", board, exp); end
        checks++; if (lat !== 21) begin errors++; $display("FAIL clear1_preload_latency got %0d expected 21", lat); end
        do_lock(0, 1, 2, 3, 0, 0, 0, 0, lat);
        exp = '0; exp[0] = 10'h001;
        checks++; if (lat !== 22) begin errors++; $display("FAIL clear1_latency got %0d expected 22", lat); end
        checks++; if (board !== exp) begin errors++; $display("FAIL clear1_board got %h expected %h", board, exp); end
        checks++; if (lines_last !== 3'd1 || lines_total !== 16'd1) begin errors++; $display("FAIL clear1_counts got %0d/%0d expected 1/1", lines_last, lines_total); end
    endtask

    task automatic test_four_rows();
        do_clear();
        checks++; if (lines_total !== 16'd0 || lines_last !== 3'd0) begin errors++; $display("FAIL clear_counts got %0d/%0d expected 0/0", lines_total, lines_last); end
        for (int r = 0; r < 4; r++) begin
            do_lock(1, 2, 3, 4, r, r, r, r, lat);
            do_lock(5, 6, 7, 8, r, r, r, r, lat);
            do_lock(9, 9, 9, 9, r, r, r, r, lat);
        end
        do_lock(0, 2, 4, 6, 4, 4, 4, 4, lat);
        do_lock(8, 8, 8, 8, 4, 4, 4, 4, lat);
        exp = '0;
        for (int r = 0; r < 4; r++) exp[r] = 10'h3FE;
        exp[4] = 10'h155;
        checks++; if (board !== exp) begin errors++; $display("FAIL tetris_preload got %h expected %h", board, exp); end
        do_lock(0, 0, 0, 0, 0, 1, 2, 3, lat);
        exp = '0; exp[0] = 10'h155;
        checks++; if (lat !== 25) begin errors++; $display("FAIL tetris_latency got %0d expected 25", lat); end
        checks++; if (board !== exp) begin errors++; $display("FAIL tetris_board got %h expected %h", board, exp); end
        checks++; if (lines_last !== 3'd4 || lines_total !== 16'd4) begin errors++; $display("FAIL tetris_counts got %0d/%0d expected 4/4", lines_last, lines_total); end
    endtask

    task automatic test_game_over();
        do_clear();
        do_lock(0, 1, 12, 3, 5, 5, 5, 20, lat);
        exp = '0; exp[5] = 10'h003;
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL game_over_set got %b expected 1", game_over); end
        checks++; if (board !== exp) begin errors++; $display("FAIL game_over_board got %h expected %h", board, exp); end
        checks++; if (lat !== 21) begin errors++; $display("FAIL game_over_latency got %0d expected 21", lat); end
        do_lock(5, 5, 5, 5, 7, 7, 7, 7, lat);
        exp[7] = 10'h020;
        checks++; if (game_over !== 1'b1 || board !== exp) begin errors++; $display("FAIL game_over_sticky got %b %h expected 1 %h", game_over, board, exp); end
        do_clear();
        checks++; if (game_over !== 1'b0 || board !== '0) begin errors++; $display("FAIL game_over_clear got %b %h expected 0 0", game_over, board); end
        checks++; if (lines_total !== 16'd0) begin errors++; $display("FAIL game_over_clear_total got %0d expected 0", lines_total); end
    endtask

    task automatic test_arbitration();
        int dones;
        do_lock(0, 1, 2, 3, 2, 2, 2, 2, lat);
        @(negedge Clk);
        x0 = 10'd4; y0 = 10'd4; lock_req = 1'b1; clear_board = 1'b1;
        @(posedge Clk); #1 lock_req = 1'b0; clear_board = 1'b0;
        checks++; if (board !== '0) begin errors++; $display("FAIL arb_clear_board got %h expected 0", board); end
        dones = 0;
        repeat (4) begin @(posedge Clk); #1; if (busy || lock_done) dones++; end
        checks++; if (dones !== 0) begin errors++; $display("FAIL arb_no_lock got %0d busy cycles expected 0", dones); end

        @(negedge Clk);
        x0 = 10'd0; x1 = 10'd1; x2 = 10'd2; x3 = 10'd3;
        y0 = 10'd1; y1 = 10'd1; y2 = 10'd1; y3 = 10'd1;
        lock_req = 1'b1;
        @(posedge Clk); #1 lock_req = 1'b0;
        x0 = 10'd9; x1 = 10'd9; x2 = 10'd9; x3 = 10'd9;
        y0 = 10'd9; y1 = 10'd9; y2 = 10'd9; y3 = 10'd9;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            lock_req    = (c >= 3 && c <= 10);
            clear_board = (c >= 5 && c <= 8);
            @(posedge Clk); #1;
            if (lock_done) dones++;
        end
        exp = '0; exp[1] = 10'h00F;
        checks++; if (dones !== 1) begin errors++; $display("FAIL back_to_back_done got %0d pulses expected 1", dones); end
        checks++; if (board !== exp) begin errors++; $display("FAIL back_to_back_board got %h expected %h", board, exp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL back_to_back_busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        do_lock(4, 5, 6, 7, 1, 1, 1, 1, lat);
        do_lock(8, 9, 0, 0, 1, 1, 3, 3, lat);
        exp = '0; exp[2] = 10'h001;
        checks++; if (board !== exp || lines_total !== 16'd1) begin errors++; $display("FAIL pre_reset_state got %h/%0d expected %h/1", board, lines_total, exp); end
        do_lock(0, 0, 0, 0, 25, 25, 25, 25, lat);
        @(negedge Clk);
        x0 = 10'd0; x1 = 10'd1; x2 = 10'd2; x3 = 10'd3;
        y0 = 10'd10; y1 = 10'd10; y2 = 10'd10; y3 = 10'd10;
        lock_req = 1'b1;
        @(posedge Clk); #1 lock_req = 1'b0;
        repeat (8) @(posedge Clk);
        #3;
        checks++; if (busy !== 1'b1 || game_over !== 1'b1) begin errors++; $display("FAIL mid_scan_busy got %b/%b expected 1/1", busy, game_over); end
        Reset = 1'b1; #1;
        checks++; if (board !== '0) begin errors++; $display("FAIL mid_reset_board got %h expected 0", board); end
        checks++; if ({busy, lock_done, game_over} !== 3'b000) begin errors++; $display("FAIL mid_reset_flags got %b expected 000", {busy, lock_done, game_over}); end
        checks++; if (lines_total !== 16'd0 || lines_last !== 3'd0) begin errors++; $display("FAIL mid_reset_counts got %0d/%0d expected 0/0", lines_total, lines_last); end
        @(posedge Clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got %b expected 0", busy); end
        @(negedge Clk); Reset = 1'b0;
        do_lock(6, 7, 8, 9, 19, 19, 19, 19, lat);
        exp = '0; exp[19] = 10'h3C0;
        checks++; if (lat !== 21 || board !== exp) begin errors++; $display("FAIL post_reset_lock got %0d %h expected 21 %h", lat, board, exp); end
    endtask

    initial begin
        test_reset();
        test_single_lock();
        test_single_clear();
        test_four_rows();
        test_game_over();
        test_arbitration();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
